// File: rtl/approx_add_arbiter.sv
// Round-robin arbiter sharing one approximate adder between NUM_REQ requesters.
// The result register is tagged with the winning requester ID and counts completed handshakes.

module approx_add_core #(
  parameter int ADDER_LENGTH   = 16,
  parameter int IMPRECISE_PART = 8,
  localparam int HI_W          = ADDER_LENGTH - IMPRECISE_PART
) (
  input  logic [HI_W-1:0]           a_hi,
  input  logic                      a_round,
  input  logic [ADDER_LENGTH-1:0]   b,
  output logic [ADDER_LENGTH:0]     sum
);

  logic [HI_W:0] carry;

  // The top bit of A's discarded low part is folded in as the carry-in.
  assign carry[0] = a_round;

  for (genvar i = 0; i < HI_W; i++) begin : g_fa
    logic p;
    assign p          = a_hi[i] ^ b[IMPRECISE_PART+i];
    assign sum[IMPRECISE_PART+i] = p ^ carry[i];
    assign carry[i+1] = (a_hi[i] & b[IMPRECISE_PART+i]) | (carry[i] & p);
  end

  assign sum[ADDER_LENGTH]           = carry[HI_W];
  assign sum[IMPRECISE_PART-1:0]     = b[IMPRECISE_PART-1:0];

endmodule

module approx_add_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  int scan_idx;

  // Scan from the slot after the last winner, wrapping around.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    scan_idx  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = int'(rr_ptr) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (enable && !grant_any && req_valid[scan_idx]) begin
        grant_any        = 1'b1;
        grant[scan_idx]  = 1'b1;
        grant_idx        = ID_W'(scan_idx);
      end
    end
  end

endmodule

module approx_add_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDER_LENGTH   = 16,
  parameter int IMPRECISE_PART = 8,
  parameter int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*ADDER_LENGTH-1:0]   req_a,
  input  logic [NUM_REQ*ADDER_LENGTH-1:0]   req_b,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [ADDER_LENGTH:0]             res_sum,
  output logic [ID_W-1:0]                   res_id,
  output logic [15:0]                       txn_count
);

  localparam int HI_W = ADDER_LENGTH - IMPRECISE_PART;

  logic                    can_accept;
  logic                    arb_en;
  logic [NUM_REQ-1:0]      grant;
  logic [ID_W-1:0]         grant_idx;
  logic                    grant_any;
  logic [ID_W-1:0]         rr_ptr;
  logic [HI_W-1:0]         op_a_hi;
  logic                    op_a_round;
  logic [ADDER_LENGTH-1:0] op_b;
  logic [ADDER_LENGTH:0]   sum_next;
  logic                    xfer;
  logic                    drain;

  assign can_accept = !res_valid || res_ready;
  // Gating with rst_n keeps req_ready low for the whole time reset is held.
  assign arb_en     = can_accept && rst_n;

  approx_add_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .enable    (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign req_ready = grant;
  assign xfer      = grant_any;
  assign drain     = res_valid && res_ready;

  always_comb begin
    op_a_hi    = req_a[int'(grant_idx)*ADDER_LENGTH + IMPRECISE_PART +: HI_W];
    op_a_round = req_a[int'(grant_idx)*ADDER_LENGTH + IMPRECISE_PART - 1];
    op_b       = req_b[int'(grant_idx)*ADDER_LENGTH +: ADDER_LENGTH];
  end

  approx_add_core #(
    .ADDER_LENGTH   (ADDER_LENGTH),
    .IMPRECISE_PART (IMPRECISE_PART)
  ) u_add (
    .a_hi    (op_a_hi),
    .a_round (op_a_round),
    .b       (op_b),
    .sum     (sum_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_sum   <= '0;
      res_id    <= '0;
      rr_ptr    <= ID_W'(NUM_REQ - 1);
    end else if (xfer) begin
      res_valid <= 1'b1;
      res_sum   <= sum_next;
      res_id    <= grant_idx;
      rr_ptr    <= grant_idx;
    end else if (drain) begin
      res_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_count <= '0;
    end else if (drain) begin
      txn_count <= txn_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_approx_add_arbiter.sv
// Self-checking bench for approx_add_arbiter: directed cases with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.

module tb_approx_add_arbiter;

  localparam int NR = 4;
  localparam int N  = 16;
  localparam int L  = 8;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*N-1:0]   req_a;
  logic [NR*N-1:0]   req_b;
  logic              res_valid;
  logic              res_ready;
  logic [N:0]        res_sum;
  logic [IW-1:0]     res_id;
  logic [15:0]       txn_count;

  int n_vec = 0;
  int n_err = 0;

  // model state
  bit          m_valid;
  logic [N:0]  m_sum;
  int          m_id;
  int          m_ptr;
  int unsigned m_txn;
  int          m_xfer;

  approx_add_arbiter #(
    .NUM_REQ        (NR),
    .ADDER_LENGTH   (N),
    .IMPRECISE_PART (L),
    .ID_W           (IW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_id    (res_id),
    .txn_count (txn_count)
  );

  always #5 clk = ~clk;

  function automatic logic [N:0] approx(input logic [N-1:0] a, input logic [N-1:0] b);
    int unsigned hi;
    int unsigned lo;
    hi = int'(a >> L) + int'(b >> L) + int'((a >> (L-1)) & 16'd1);
    lo = int'(b) % (1 << L);
    return 17'((hi << L) + lo);
  endfunction

  function automatic int pick(input logic [NR-1:0] v, input int ptr, input bit mv, input logic rr);
    if (mv && !rr) return -1;
    for (int k = 1; k <= NR; k++)
      if (v[(ptr + k) % NR]) return (ptr + k) % NR;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0;
      m_sum   = '0;
      m_id    = 0;
      m_ptr   = NR - 1;
      m_txn   = 0;
      m_xfer  = -1;
    end else begin
      int g;
      g = pick(req_valid, m_ptr, m_valid, res_ready);
      if (m_valid && res_ready) m_txn = (m_txn + 1) % 65536;
      if (g >= 0) begin
        m_sum   = approx(req_a[g*N +: N], req_b[g*N +: N]);
        m_id    = g;
        m_valid = 1'b1;
        m_ptr   = g;
      end else if (m_valid && res_ready) begin
        m_valid = 1'b0;
      end
      m_xfer = g;
    end
  end

  always @(negedge clk) begin
    int g;
    logic [NR-1:0] er;
    er = '0;
    if (rst_n) begin
      g = pick(req_valid, m_ptr, m_valid, res_ready);
      if (g >= 0) er[g] = 1'b1;
    end
    chk("cyc_req_ready", 32'(req_ready), 32'(er));
    chk("cyc_res_valid", 32'(res_valid), 32'(m_valid));
    if (m_valid) begin
      chk("cyc_res_sum", 32'(res_sum), 32'(m_sum));
      chk("cyc_res_id", 32'(res_id), 32'(m_id));
    end
    chk("cyc_txn_count", 32'(txn_count), m_txn);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    res_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    res_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;

    // 1: first transaction after reset
    do_reset();
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_txn", 32'(txn_count), 32'd0);
    set_op(0, 16'h1280, 16'h3405);
    req_valid = 4'b0001;
    res_ready = 1'b1;
    #1 chk("t1_ready", 32'(req_ready), 32'b0001);
    step();
    chk("t1_valid", 32'(res_valid), 32'd1);
    chk("t1_sum", 32'(res_sum), 32'h04705);
    chk("t1_id", 32'(res_id), 32'd0);
    req_valid = '0;
    step();
    chk("t1_txn", 32'(txn_count), 32'd1);

    // 2: carry-out through the exact upper part
    set_op(2, 16'hFF80, 16'h0011);
    req_valid = 4'b0100;
    step();
    chk("t2_sum_carry", 32'(res_sum), 32'h10011);
    chk("t2_id", 32'(res_id), 32'd2);
    set_op(2, 16'hFF7F, 16'h0011);
    step();
    chk("t2_sum_nocarry", 32'(res_sum), 32'h0FF11);
    req_valid = '0;
    step();

    // 3: all four continuously valid
    do_reset();
    for (int i = 0; i < NR; i++) set_op(i, 16'($urandom), 16'($urandom));
    req_valid = 4'b1111;
    res_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1 chk("t3_grant", 32'(req_ready), 32'(1 << (k % NR)));
      step();
      chk("t3_res_id", 32'(res_id), 32'(k % NR));
    end

    // 4: backpressure with req 1 and req 3 pending
    do_reset();
    set_op(1, 16'h1111, 16'h2222);
    set_op(3, 16'h0180, 16'h0001);
    req_valid = 4'b1010;
    res_ready = 1'b1;
    #1 chk("t4_grant1", 32'(req_ready), 32'b0010);
    step();
    res_ready = 1'b0;
    chk("t4_id1", 32'(res_id), 32'd1);
    for (int k = 0; k < 3; k++) begin
      #1 chk("t4_bp_ready", 32'(req_ready), 32'd0);
      step();
      chk("t4_bp_valid", 32'(res_valid), 32'd1);
      chk("t4_bp_sum", 32'(res_sum), 32'h03322);
      chk("t4_bp_id", 32'(res_id), 32'd1);
      chk("t4_bp_txn", 32'(txn_count), 32'd0);
    end
    res_ready = 1'b1;
    #1 chk("t4_grant3", 32'(req_ready), 32'b1000);
    step();
    chk("t4_id3", 32'(res_id), 32'd3);
    chk("t4_sum3", 32'(res_sum), 32'h00201);
    chk("t4_txn1", 32'(txn_count), 32'd1);
    req_valid = 4'b0010;
    #1 chk("t4_grant1b", 32'(req_ready), 32'b0010);
    step();
    chk("t4_txn2", 32'(txn_count), 32'd2);
    req_valid = '0;
    step();
    chk("t4_txn3", 32'(txn_count), 32'd3);
    chk("t4_drained", 32'(res_valid), 32'd0);

    // 5: asynchronous reset during backpressure
    set_op(0, 16'h0101, 16'h0202);
    req_valid = 4'b0001;
    res_ready = 1'b0;
    step();
    chk("t5_pending", 32'(res_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_valid", 32'(res_valid), 32'd0);
    chk("t5_async_txn", 32'(txn_count), 32'd0);
    chk("t5_async_sum", 32'(res_sum), 32'd0);
    chk("t5_async_ready", 32'(req_ready), 32'd0);
    step();
    rst_n     = 1'b1;
    req_valid = 4'b1111;
    res_ready = 1'b1;
    #1 chk("t5_first_grant", 32'(req_ready), 32'b0001);
    step();
    chk("t5_first_id", 32'(res_id), 32'd0);

    // randomized traffic under the protocol: operands hold until granted
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] || m_xfer == i) begin
          req_valid[i] = ($urandom_range(0, 99) < 45);
          set_op(i, 16'($urandom), 16'($urandom));
        end
      end
      res_ready = ($urandom_range(0, 99) < 70);
      step();
    end

    // 6: txn_count wrap
    do_reset();
    set_op(0, 16'h0F0F, 16'h00F0);
    req_valid = 4'b0001;
    res_ready = 1'b1;
    for (int k = 0; k < 65536; k++) step();
    chk("t6_txn_max", 32'(txn_count), 32'h0000FFFF);
    req_valid = '0;
    step();
    chk("t6_txn_wrap", 32'(txn_count), 32'h00000000);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/approx_add_arbiter.md
Name: approx_add_arbiter

Overview:
- Shares one approximate adder between NUM_REQ requesters using round-robin arbitration with valid/ready handshakes.
- The result is registered and tagged with the winning requester's ID.
- Sits between the PE-side partial-sum producers and the accumulation path, so one approximate adder can serve several producers instead of one adder per producer.
- Also keeps a wrapping count of completed transactions for the performance monitors.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDER_LENGTH, 16, operand width in bits.
- IMPRECISE_PART, 8, number of LSBs handled by the approximate lower part (1..ADDER_LENGTH-1).
- ID_W, $clog2(NUM_REQ), width of the requester ID tag.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester grant/accept, one-hot or zero.
- req_a  in  NUM_REQ*ADDER_LENGTH  flattened operand A; requester i uses slice [i*ADDER_LENGTH +: ADDER_LENGTH].
- req_b  in  NUM_REQ*ADDER_LENGTH  flattened operand B, same slicing.
- res_valid  out  1  result register holds a valid result.
- res_ready  in  1  downstream accepts the result.
- res_sum  out  ADDER_LENGTH+1  approximate sum including carry-out.
- res_id  out  ID_W  index of the requester that produced res_sum.
- txn_count  out  16  completed result handshakes, wraps modulo 2^16.

Behaviour:
- Arithmetic, with L = IMPRECISE_PART and N = ADDER_LENGTH:
  - sum[L-1:0] = b[L-1:0]; A's low bits are ignored.
  - sum[N:L] = a[N-1:L] + b[N-1:L] + a[L-1], computed as an exact ripple sum; the carry-out goes to sum[N].
  - The arithmetic is combinational on the granted operands and is captured into the result register.
- Accept condition: can_accept = !res_valid || res_ready.
- Arbitration is combinational:
  - When can_accept is high, the grant goes to the first asserted req_valid, scanning from rr_ptr+1 upward and wrapping modulo NUM_REQ.
  - req_ready = that one-hot grant. req_ready is all-zero when can_accept is low or no request is asserted.
  - A transfer occurs on requester i when req_valid[i] && req_ready[i].
- On a transfer edge:
  - res_sum <= approximate sum of the granted operands.
  - res_id <= granted index.
  - res_valid <= 1.
  - rr_ptr <= granted index.
- rr_ptr updates only on a transfer; no request means no pointer movement.
- Latency: result visible one cycle after the accept edge.
- Throughput: one result per cycle while res_ready is held high.
- Output drain:
  - If res_valid && res_ready and no new transfer happens, res_valid <= 0.
  - A drain and a new accept in the same cycle are allowed; the register is simply overwritten with the new result and res_valid stays 1.
- Backpressure: while res_valid && !res_ready, res_sum, res_id and res_valid hold stable, all req_ready are 0, and rr_ptr holds.
- txn_count increments on every res_valid && res_ready edge and wraps from 0xFFFF to 0.
- Requester protocol: once a requester asserts req_valid, it holds req_valid and its operands stable until granted. The arbiter does not check this.
- Reset (asynchronous assert, any time including mid-backpressure):
  - res_valid = 0, res_sum = 0, res_id = 0, txn_count = 0.
  - rr_ptr = NUM_REQ-1, so requester 0 has first priority after reset.
  - req_ready = 0 while rst_n is low.
  - A pending result is discarded and not counted.
- Single requester continuously valid: granted every cycle that can_accept is high.

Test Plan (NUM_REQ=4, ADDER_LENGTH=16, IMPRECISE_PART=8):
1. Reset release; only req 0 asserts valid with a=0x1280, b=0x3405; res_ready=1.
   - req_ready=4'b0001 the same cycle.
   - Next cycle: res_valid=1, res_sum=0x04705, res_id=0.
   - txn_count=1 after the handshake.
2. Carry-out case: req 2 only, a=0xFF80, b=0x0011.
   - res_sum=0x10011, res_id=2.
   - Repeat with a=0xFF7F, b=0x0011: res_sum=0x0FF11.
3. All four requesters held valid continuously, res_ready=1, starting from reset.
   - Grants in order 0,1,2,3,0,1: one per cycle, each one-hot.
   - res_id follows the same order one cycle later.
4. Backpressure: res_ready=0 for 3 cycles while req 1 and req 3 are valid.
   - res_sum/res_id held stable and req_ready=0 throughout; txn_count unchanged.
   - When res_ready rises: the next grant goes to the requester after the last grant, and exactly one result is counted per handshake.
5. Assert rst_n=0 mid-stream while res_valid=1 and res_ready=0.
   - res_valid=0 and txn_count=0 immediately, without waiting for a clock edge.
   - After release with all requesters valid, the first grant is req 0.
6. txn_count wrap: preload via 65535 handshakes, then one more → txn_count=0x0000.
